// File: rtl/voltcalc_pkg.sv
// Shared state type, constants and width helpers for the sequential
// ADC-code-to-ASCII-voltage converter.
package voltcalc_pkg;

    typedef enum logic [2:0] {IDLE, MUL, DIV, BCD, DONE} state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam int         BCD_BITS   = 10;

    function automatic int fullScale(input int adcW);
        return (1 << adcW) - 1;
    endfunction

    function automatic int prodWidth(input int adcW);
        return adcW + 10;
    endfunction

endpackage

// File: rtl/voltcalc_bin2bcd.sv
// Sequential 10-bit double-dabble: start_i loads bin_i and performs the first
// step, done_o pulses for one cycle once all ten steps have been applied.
module voltcalc_bin2bcd
    import voltcalc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [BCD_BITS-1:0] bin_i,
    output logic                done_o,
    output logic [3:0]          hundreds_o,
    output logic [3:0]          tens_o,
    output logic [3:0]          units_o
);
    localparam int WORK_W = BCD_BITS + 12;

    logic [WORK_W-1:0] work_q, work_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // One double-dabble step over the {BCD digits, binary remainder} word.
    function automatic logic [WORK_W-1:0] dabble(input logic [WORK_W-1:0] v);
        logic [WORK_W-1:0] r;
        r = v;
        for (int d = 0; d < 3; d++) begin
            if (r[BCD_BITS + 4*d +: 4] >= 4'd5) begin
                r[BCD_BITS + 4*d +: 4] = r[BCD_BITS + 4*d +: 4] + 4'd3;
            end
        end
        return r << 1;
    endfunction

    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i && !busy_q) begin
            work_d = dabble({12'd0, bin_i});
            cnt_d  = 4'd1;
            busy_d = 1'b1;
        end else if (busy_q) begin
            work_d = dabble(work_q);
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'(BCD_BITS - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done_o     = done_q;
    assign hundreds_o = work_q[WORK_W-1 -: 4];
    assign tens_o     = work_q[WORK_W-5 -: 4];
    assign units_o    = work_q[WORK_W-9 -: 4];

endmodule

// File: rtl/voltage_calculator_seq.sv
// Multi-channel sequential ADC-code to ASCII voltage converter (shift-add, restoring divide, BCD).
// Build option VOLTCALC_ROUND_EN selects round-half-up; the default build truncates.
module voltage_calculator_seq
    import voltcalc_pkg::*;
#(
    parameter  int ADC_W   = 12,
    parameter  int VREF_CV = 330,
    parameter  int NUM_CH  = 4,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ADC_W-1:0] ADC_data,
    input  logic [CH_W-1:0]  in_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [7:0]       integer_data,
    output logic [7:0]       float1_data,
    output logic [7:0]       float2_data
);
    localparam int                PROD_W = prodWidth(ADC_W);
    localparam int                CNT_W  = $clog2(PROD_W + 1);
    localparam logic [ADC_W-1:0]  FS_V   = ADC_W'(fullScale(ADC_W));
    localparam logic [PROD_W-1:0] VREF_P = PROD_W'(VREF_CV);
`ifdef VOLTCALC_ROUND_EN
    localparam logic [PROD_W-1:0] ROUND_P = PROD_W'(fullScale(ADC_W) / 2);
`else
    localparam logic [PROD_W-1:0] ROUND_P = '0;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADC_W-1:0]  code_q, code_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [ADC_W-1:0]  rem_q, rem_d;
    logic              inReady_q, inReady_d;
    logic              outValid_q, outValid_d;
    logic [CH_W-1:0]   outCh_q, outCh_d;
    logic [7:0]        intData_q, intData_d;
    logic [7:0]        frac1_q, frac1_d;
    logic [7:0]        frac2_q, frac2_d;

    logic [PROD_W-1:0] mulSum;
    logic [ADC_W:0]    remShift;
    logic [ADC_W-1:0]  remDiff;
    logic              geFs;
    logic              bcdStart, bcdDone;
    logic [3:0]        bcdHund, bcdTens, bcdUnits;

    // acc_q is the product during MUL and doubles as dividend/quotient during DIV.
    always_comb begin
        mulSum   = {acc_q[PROD_W-2:0], 1'b0} + (code_q[ADC_W-1] ? VREF_P : '0);
        remShift = {rem_q, acc_q[PROD_W-1]};
        geFs     = (remShift >= {1'b0, FS_V});
        remDiff  = remShift[ADC_W-1:0] - FS_V;
        bcdStart = (state_q == BCD) && (cnt_q == '0);

        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        ch_d       = ch_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        inReady_d  = inReady_q;
        outValid_d = outValid_q;
        outCh_d    = outCh_q;
        intData_d  = intData_q;
        frac1_d    = frac1_q;
        frac2_d    = frac2_q;

        unique case (state_q)
            IDLE: begin
                inReady_d = 1'b1;
                if (in_valid && inReady_q) begin
                    inReady_d = 1'b0;
                    code_d    = ADC_data;
                    ch_d      = in_ch;
                    acc_d     = '0;
                    cnt_d     = '0;
                    state_d   = MUL;
                end
            end
            MUL: begin
                acc_d  = mulSum;
                code_d = code_q << 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ADC_W - 1)) begin
                    acc_d   = mulSum + ROUND_P;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                rem_d = geFs ? remDiff : remShift[ADC_W-1:0];
                acc_d = {acc_q[PROD_W-2:0], geFs};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PROD_W - 1)) begin
                    cnt_d   = '0;
                    state_d = BCD;
                end
            end
            BCD: begin
                if (bcdStart) begin
                    cnt_d = CNT_W'(1);
                end
                if (bcdDone) begin
                    intData_d  = ASCII_ZERO + {4'd0, bcdHund};
                    frac1_d    = ASCII_ZERO + {4'd0, bcdTens};
                    frac2_d    = ASCII_ZERO + {4'd0, bcdUnits};
                    outCh_d    = ch_q;
                    outValid_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    inReady_d  = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            code_q     <= '0;
            ch_q       <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            inReady_q  <= 1'b0;
            outValid_q <= 1'b0;
            outCh_q    <= '0;
            intData_q  <= ASCII_ZERO;
            frac1_q    <= ASCII_ZERO;
            frac2_q    <= ASCII_ZERO;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            ch_q       <= ch_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            inReady_q  <= inReady_d;
            outValid_q <= outValid_d;
            outCh_q    <= outCh_d;
            intData_q  <= intData_d;
            frac1_q    <= frac1_d;
            frac2_q    <= frac2_d;
        end
    end

    voltcalc_bin2bcd u_bin2bcd (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (bcdStart),
        .bin_i      (acc_q[BCD_BITS-1:0]),
        .done_o     (bcdDone),
        .hundreds_o (bcdHund),
        .tens_o     (bcdTens),
        .units_o    (bcdUnits)
    );

    assign in_ready     = inReady_q;
    assign out_valid    = outValid_q;
    assign out_ch       = outCh_q;
    assign integer_data = intData_q;
    assign float1_data  = frac1_q;
    assign float2_data  = frac2_q;

endmodule

// File: tb/tb_voltage_calculator_seq.sv
// Scoreboard bench for voltage_calculator_seq: default instance plus a 10-bit / 5.00 V instance.
module tb_voltage_calculator_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inValid = 1'b0, inReady, outValid, outReady = 1'b0;
    logic [11:0] adcData = '0;
    logic [1:0]  inCh = '0, outCh;
    logic [7:0]  intData, f1Data, f2Data;

    logic        inValid10 = 1'b0, inReady10, outValid10, outReady10 = 1'b0;
    logic [9:0]  adcData10 = '0;
    logic        inCh10 = 1'b0, outCh10;
    logic [7:0]  int10, f1_10, f2_10;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d2;
        logic [7:0] d1;
        logic [7:0] d0;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   acceptCycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    voltage_calculator_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady),
        .ADC_data(adcData), .in_ch(inCh), .out_valid(outValid), .out_ready(outReady),
        .out_ch(outCh), .integer_data(intData), .float1_data(f1Data), .float2_data(f2Data)
    );

    voltage_calculator_seq #(.ADC_W(10), .VREF_CV(500), .NUM_CH(1)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid10), .in_ready(inReady10),
        .ADC_data(adcData10), .in_ch(inCh10), .out_valid(outValid10), .out_ready(outReady10),
        .out_ch(outCh10), .integer_data(int10), .float1_data(f1_10), .float2_data(f2_10)
    );

    // Reference: centivolts by integer arithmetic, then decimal digits as ASCII.
    function automatic exp_t model(input int adcW, input int vref, input int code, input int ch);
        exp_t   r;
        longint fs;
        longint p;
        int     cv;
        fs = (longint'(1) << adcW) - 1;
        p  = longint'(code) * vref;
`ifdef VOLTCALC_ROUND_EN
        p  = p + fs / 2;
`endif
        cv   = int'(p / fs);
        r.ch = 2'(ch);
        r.d2 = 8'h30 + 8'(cv / 100);
        r.d1 = 8'h30 + 8'((cv / 10) % 10);
        r.d0 = 8'h30 + 8'(cv % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] code, input logic [1:0] ch);
        int n;
        n = 0;
        @(negedge clk);
        while (!inReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(inReady), 32'd1);
        adcData     = code;
        inCh        = ch;
        inValid     = 1'b1;
        acceptCycle = cycle + 1;
        expQ.push_back(model(12, 330, int'(code), int'(ch)));
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic waitOut(output int lat);
        int n;
        n = 0;
        while (!outValid && n < 300) begin
            @(negedge clk);
            n++;
        end
        lat = outValid ? (cycle - acceptCycle) : -1;
    endtask

    task automatic checkOutput(input string tag, input int expLat);
        int   lat;
        exp_t e;
        waitOut(lat);
        check({tag, "_latency"}, 32'(lat), 32'(expLat));
        if (expQ.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            check({tag, "_ch"}, 32'(outCh), 32'(e.ch));
            check({tag, "_int"}, 32'(intData), 32'(e.d2));
            check({tag, "_f1"}, 32'(f1Data), 32'(e.d1));
            check({tag, "_f2"}, 32'(f2Data), 32'(e.d0));
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        check({tag, "_valid_drop"}, 32'(outValid), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        int   lat;
        int   n;

        $display("[TB] reset phase");
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(inReady), 32'd0);
        check("rst_out_valid", 32'(outValid), 32'd0);
        check("rst_out_ch", 32'(outCh), 32'd0);
        check("rst_int", 32'(intData), 32'h30);
        check("rst_f1", 32'(f1Data), 32'h30);
        check("rst_f2", 32'(f2Data), 32'h30);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 32'(inReady), 32'd1);

        $display("[TB] directed conversions");
        applyStimulus(12'd4095, 2'd2);
        checkOutput("full_scale", 45);
        applyStimulus(12'd2048, 2'd1);
        checkOutput("mid_2048", 45);
        applyStimulus(12'd0, 2'd3);
        checkOutput("zero", 45);
        applyStimulus(12'd2047, 2'd0);
        checkOutput("mid_2047", 45);

        $display("[TB] back-pressure");
        applyStimulus(12'd1234, 2'd1);
        adcData = 12'd3000;
        inCh    = 2'd3;
        inValid = 1'b1;
        waitOut(lat);
        check("bp_latency", 32'(lat), 32'd45);
        e = (expQ.size() != 0) ? expQ.pop_front() : '0;
        for (int i = 0; i < 20; i++) begin
            check("bp_valid_held", 32'(outValid), 32'd1);
            check("bp_in_ready_low", 32'(inReady), 32'd0);
            check("bp_outputs_stable", {6'd0, outCh, intData, f1Data, f2Data},
                  {6'd0, e.ch, e.d2, e.d1, e.d0});
            @(negedge clk);
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        check("bp_valid_drop", 32'(outValid), 32'd0);
        check("bp_in_ready_rise", 32'(inReady), 32'd1);
        acceptCycle = cycle + 1;
        expQ.push_back(model(12, 330, 3000, 3));
        @(negedge clk);
        inValid = 1'b0;
        check("bp_queued_accepted", 32'(inReady), 32'd0);
        checkOutput("bp_queued", 45);

        $display("[TB] reset during divide");
        applyStimulus(12'd4000, 2'd1);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(outValid), 32'd0);
        check("abort_in_ready", 32'(inReady), 32'd0);
        check("abort_out_ch", 32'(outCh), 32'd0);
        check("abort_digits", {8'd0, intData, f1Data, f2Data}, 32'h00303030);
        expQ.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(12'd1000, 2'd0);
        checkOutput("after_abort", 45);

        $display("[TB] 10-bit 5.00 V instance");
        n = 0;
        @(negedge clk);
        while (!inReady10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        adcData10   = 10'd1023;
        inCh10      = 1'b1;
        inValid10   = 1'b1;
        acceptCycle = cycle + 1;
        @(negedge clk);
        inValid10 = 1'b0;
        n = 0;
        while (!outValid10 && n < 300) begin
            @(negedge clk);
            n++;
        end
        e = model(10, 500, 1023, 1);
        check("w10_latency", 32'(outValid10 ? (cycle - acceptCycle) : -1), 32'd41);
        check("w10_ch", 32'(outCh10), 32'(e.ch));
        check("w10_int", 32'(int10), 32'(e.d2));
        check("w10_f1", 32'(f1_10), 32'(e.d1));
        check("w10_f2", 32'(f2_10), 32'(e.d0));
        outReady10 = 1'b1;
        @(negedge clk);
        outReady10 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
